fifo_rd_stream: RTL and testbench

// - Read-side consumer of the FIFO memory's registered read port. Issues read enables to the memory and read pointer.
// - Absorbs the memory's 1-cycle read latency into a small skid buffer.
// - Presents words downstream on a valid/ready stream. Sits in the rclk domain, after the read-pointer/empty logic.

---
 rtl/fifo_rd_stream.sv | 58 +++++
 tb/tb_fifo_rd_stream.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side stream stage for the FIFO memory. Issues reads against a credit
// count and parks the registered read data in a small skid buffer.
module fifo_rd_stream #(
    parameter int DATA_SIZE = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic                        rclk,
    input  logic                        rrst,
    input  logic                        rempty,
    input  logic [DATA_SIZE-1:0]        rdata,
    output logic                        rd_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_SIZE-1:0]        out_data,
    output logic [$clog2(BUF_DEPTH):0]  buf_count,
    output logic                        ovf_err
);
    localparam int            PW       = $clog2(BUF_DEPTH);
    localparam logic [PW+1:0] DEPTH_W  = (PW+2)'(BUF_DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(BUF_DEPTH);

    logic [DATA_SIZE-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 inflight;
    logic                 pop, full, push_ok;
    logic [PW+1:0]        credit;

    assign out_valid = (buf_count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign full      = (buf_count == FULL_CNT);
    assign push_ok   = inflight & (!full | pop);

    // Count the word still in flight plus the slot freed by this cycle's pop,
    // so a read is only issued when its data is guaranteed a slot.
    assign credit = {1'b0, buf_count} + (PW+2)'(inflight) - (PW+2)'(pop);
    assign rd_en  = !rrst & !rempty & (credit < DEPTH_W);

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
            ovf_err   <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            inflight <= rd_en;
            if (push_ok) begin
                mem[wr_ptr] <= rdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (inflight & full & !pop) ovf_err <= 1'b1;
            buf_count <= buf_count + (PW+1)'(push_ok) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a FIFO memory model feeds rdata, a
// scoreboard queue holds issued words and is drained as the stream pops.
module tb_fifo_rd_stream;
    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       rempty = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] rdata = 8'hEE;
    logic       rd_en, out_valid, ovf_err;
    logic [7:0] out_data;
    logic [1:0] buf_count;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] mem_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pend = 8'hEE;

    fifo_rd_stream #(.DATA_SIZE(8), .BUF_DEPTH(2)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata),
        .rd_en(rd_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .buf_count(buf_count), .ovf_err(ovf_err)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: registered read port, data valid the cycle after rd_en.
    always @(posedge rclk) begin
        #1;
        rdata  = pend;
        rempty = (mem_q.size() == 0);
    end

    // Issue / pop monitor, sampled mid-cycle.
    always @(negedge rclk) begin
        if (!rrst) begin
            pend = 8'hEE;
            if (rd_en) begin
                chk("rd_en_while_empty", rempty, 0);
                chk("rd_en_model_has_word", mem_q.size() != 0, 1);
                if (mem_q.size() != 0) begin
                    pend = mem_q.pop_front();
                    exp_q.push_back(pend);
                end
            end
            if (out_valid && out_ready) begin
                chk("pop_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        // T1: reset holds everything off even with data available
        mem_q.push_back(8'hA5);
        for (int c = 0; c < 3; c++) begin
            @(negedge rclk);
            chk("t1_rd_en", rd_en, 0);
            chk("t1_out_valid", out_valid, 0);
            chk("t1_out_data", out_data, 0);
            chk("t1_buf_count", buf_count, 0);
        end

        // T2: single word, latency rd_en N -> out_valid N+2
        @(posedge rclk); #1 rrst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge rclk);
            chk("t2_rd_en", rd_en, c == 0);
            chk("t2_out_valid", out_valid, c == 2);
            if (c == 2) chk("t2_out_data", out_data, 8'hA5);
        end

        // T3: full-throughput streaming
        for (int i = 0; i < 16; i++) mem_q.push_back(8'(i));
        for (int c = 0; c < 19; c++) begin
            @(negedge rclk);
            chk("t3_rd_en", rd_en, c < 16);
            chk("t3_out_valid", out_valid, c >= 2 && c < 18);
            if (c >= 2 && c < 18) chk("t3_out_data", out_data, c - 2);
        end

        // T4: backpressure cycles 5..9, then release
        for (int i = 0; i < 16; i++) mem_q.push_back(8'(8'h20 + i));
        for (int c = 0; c < 24; c++) begin
            @(posedge rclk); #1 out_ready = !(c >= 5 && c < 10);
            @(negedge rclk);
            chk("t4_rd_en", rd_en, (c < 5) || (c >= 10 && c <= 20));
            chk("t4_out_valid", out_valid, c >= 2 && c <= 22);
            if (c >= 5 && c < 10) chk("t4_out_data_stable", out_data, 8'h23);
            if (c >= 6 && c < 10) chk("t4_buf_count", buf_count, 2);
        end
        chk("t4_ovf_err", ovf_err, 0);

        // T5: source empties after 3 issues; out_ready toggles while idle
        for (int i = 0; i < 3; i++) mem_q.push_back(8'(8'h30 + i));
        for (int c = 0; c < 9; c++) begin
            @(posedge rclk); #1 out_ready = (c < 5) ? 1'b1 : c[0];
            @(negedge rclk);
            chk("t5_rd_en", rd_en, c < 3);
            chk("t5_out_valid", out_valid, c >= 2 && c < 5);
            if (c >= 2 && c < 5) chk("t5_out_data", out_data, 8'h30 + c - 2);
        end
        @(posedge rclk); #1;
        chk("t5_scoreboard_drained", exp_q.size(), 0);
        chk("t5_buf_count", buf_count, 0);

        // T6: asynchronous reset with one word buffered and one in flight
        for (int i = 0; i < 8; i++) mem_q.push_back(8'(8'h40 + i));
        for (int c = 0; c < 3; c++) begin
            @(posedge rclk); #1 out_ready = 1'b0;
            @(negedge rclk);
            chk("t6_rd_en", rd_en, c < 2);
        end
        chk("t6_pre_buf_count", buf_count, 1);
        #2 rrst = 1'b1;
        #1;
        chk("t6_async_out_valid", out_valid, 0);
        chk("t6_async_buf_count", buf_count, 0);
        chk("t6_async_rd_en", rd_en, 0);
        chk("t6_async_out_data", out_data, 0);
        mem_q.delete();
        exp_q.delete();
        mem_q.push_back(8'h5A);
        mem_q.push_back(8'h5B);
        out_ready = 1'b1;
        @(posedge rclk); #1 rrst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge rclk);
            chk("t6_post_rd_en", rd_en, c < 2);
            chk("t6_post_out_valid", out_valid, c == 2 || c == 3);
            if (c == 2) chk("t6_post_out_data0", out_data, 8'h5A);
            if (c == 3) chk("t6_post_out_data1", out_data, 8'h5B);
        end

        @(posedge rclk); #1;
        chk("final_scoreboard_drained", exp_q.size(), 0);
        chk("final_ovf_err", ovf_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
